alu_arbiter: RTL and testbench

Shares the single execute-stage ALU between two requesters, such as the main execute path and an address/auxiliary unit. Each requester uses a valid/ready handshake. The block:

- picks one request at a time;
- drives the ALU from registered operands;
- captures the result and flags into a response register;
- owns the architectural status register `{Z,C,N,V}`, which feeds the ALU carry-in.

It sits between the ID/EXE pipeline register and the ALU.

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the ID/EXE requesters, the shared ALU and the response consumer.
// master = environment side (requesters, ALU, consumer); slave = alu_arbiter.
interface alu_arbiter_if #(
    parameter int unsigned REG_LEN = 32,
    parameter int unsigned CMD_LEN = 4
);
    logic               req0_valid;
    logic               req1_valid;
    logic               req0_ready;
    logic               req1_ready;
    logic [CMD_LEN-1:0] req0_cmd;
    logic [CMD_LEN-1:0] req1_cmd;
    logic [REG_LEN-1:0] req0_op1;
    logic [REG_LEN-1:0] req0_op2;
    logic [REG_LEN-1:0] req1_op1;
    logic [REG_LEN-1:0] req1_op2;
    logic               req0_set_status;
    logic               req1_set_status;
    logic [REG_LEN-1:0] alu_in1;
    logic [REG_LEN-1:0] alu_in2;
    logic [CMD_LEN-1:0] alu_command;
    logic               alu_cin;
    logic [REG_LEN-1:0] alu_out;
    logic [3:0]         alu_status;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [REG_LEN-1:0] rsp_data;
    logic [3:0]         rsp_status;
    logic [3:0]         status_reg;

    modport master (
        output req0_valid, req1_valid, req0_cmd, req1_cmd,
        output req0_op1, req0_op2, req1_op1, req1_op2,
        output req0_set_status, req1_set_status,
        output alu_out, alu_status, rsp_ready,
        input  req0_ready, req1_ready, alu_in1, alu_in2, alu_command, alu_cin,
        input  rsp_valid, rsp_id, rsp_data, rsp_status, status_reg
    );

    modport slave (
        input  req0_valid, req1_valid, req0_cmd, req1_cmd,
        input  req0_op1, req0_op2, req1_op1, req1_op2,
        input  req0_set_status, req1_set_status,
        input  alu_out, alu_status, rsp_ready,
        output req0_ready, req1_ready, alu_in1, alu_in2, alu_command, alu_cin,
        output rsp_valid, rsp_id, rsp_data, rsp_status, status_reg
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared execute-stage ALU; owns the {Z,C,N,V} status register.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: port 0 fixed priority).
module alu_arbiter #(
    parameter int unsigned REG_LEN = 32,
    parameter int unsigned CMD_LEN = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CMD_LEN-1:0] r_cmd;
    logic [REG_LEN-1:0] r_op1;
    logic [REG_LEN-1:0] r_op2;
    logic               r_set_status;
    logic               r_id;
    logic               r_rsp_id;
    logic [REG_LEN-1:0] r_rsp_data;
    logic [3:0]         r_rsp_status;
    logic [3:0]         r_status;
    logic               w_can_grant;
    logic               w_pick1;
    logic               w_grant0;
    logic               w_grant1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic               r_last_grant;

    // Contended: serve the port that did not win last; reset value 1 favours port 0 first.
    assign w_pick1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0 || w_grant1) begin
            r_last_grant <= w_grant1;
        end
    end
`else
    assign w_pick1 = bus.req1_valid && !bus.req0_valid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_can_grant  = 1'b0;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            IDLE:    w_can_grant = 1'b1;
            EXEC:    w_next_state = RESP;
            RESP: begin
                w_can_grant = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
        // ready must stay low while reset is held even though the state decodes as IDLE
        w_can_grant = w_can_grant && rst;
        if (w_can_grant) begin
            w_grant1 = w_pick1;
            w_grant0 = bus.req0_valid && !w_pick1;
            if (w_grant0 || w_grant1) begin
                w_next_state = EXEC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd        <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_set_status <= 1'b0;
            r_id         <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_status     <= '0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_cmd        <= w_grant1 ? bus.req1_cmd        : bus.req0_cmd;
                r_op1        <= w_grant1 ? bus.req1_op1        : bus.req0_op1;
                r_op2        <= w_grant1 ? bus.req1_op2        : bus.req0_op2;
                r_set_status <= w_grant1 ? bus.req1_set_status : bus.req0_set_status;
                r_id         <= w_grant1;
            end
            if (r_state == EXEC) begin
                r_rsp_data   <= bus.alu_out;
                r_rsp_status <= bus.alu_status;
                r_rsp_id     <= r_id;
                if (r_set_status) begin
                    r_status <= bus.alu_status;
                end
            end
        end
    end

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.alu_in1     = r_op1;
    assign bus.alu_in2     = r_op2;
    assign bus.alu_command = r_cmd;
    assign bus.alu_cin     = r_status[2];
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_status  = r_rsp_status;
    assign bus.status_reg  = r_status;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small reference ALU (ADD/ADC/SUB, C = carry / borrow).
// Expected ids in the contention test depend on ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;
    localparam int unsigned RL = 32;
    localparam int unsigned CL = 4;
    localparam logic [3:0] C_ADD = 4'd0;
    localparam logic [3:0] C_ADC = 4'd1;
    localparam logic [3:0] C_SUB = 4'd2;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [3:0]  sreg;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    exp_t   q[$];
    int     pop_cyc[$];
    exp_t   e_mon;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.REG_LEN(RL), .CMD_LEN(CL)) bus();

    alu_arbiter #(.REG_LEN(RL), .CMD_LEN(CL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [32:0] w_sum;
    logic [31:0] w_res;
    always_comb begin
        w_sum = '0;
        case (bus.alu_command)
            C_ADD:   w_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
            C_ADC:   w_sum = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2} + {32'b0, bus.alu_cin};
            C_SUB:   w_sum = {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};
            default: w_sum = {1'b0, bus.alu_in1};
        endcase
        w_res = w_sum[31:0];
        bus.alu_out       = w_res;
        bus.alu_status[3] = (w_res == 32'd0);
        bus.alu_status[2] = w_sum[32];
        bus.alu_status[1] = w_res[31];
        if (bus.alu_command == C_SUB)
            bus.alu_status[0] = (bus.alu_in1[31] != bus.alu_in2[31]) && (w_res[31] != bus.alu_in1[31]);
        else
            bus.alu_status[0] = (bus.alu_in1[31] == bus.alu_in2[31]) && (w_res[31] != bus.alu_in1[31]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: compares every accepted response against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            chk("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d data 0x%0h expected no response", bus.rsp_id, bus.rsp_data);
                end else begin
                    e_mon = q.pop_front();
                    chk("rsp_id",     32'(bus.rsp_id),     32'(e_mon.id));
                    chk("rsp_data",   bus.rsp_data,        e_mon.data);
                    chk("rsp_status", 32'(bus.rsp_status), 32'(e_mon.flags));
                    chk("status_reg", 32'(bus.status_reg), 32'(e_mon.sreg));
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    // Called just after a posedge; returns #1 after the handshake edge with valid dropped.
    task automatic issue(input int port, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic set, input logic push, input logic [31:0] edata,
                         input logic [3:0] eflags, input logic [3:0] esreg);
        exp_t t;
        bit   done;
        done = 1'b0;
        if (push) begin
            t.id = (port == 1);
            t.data = edata;
            t.flags = eflags;
            t.sreg = esreg;
            q.push_back(t);
        end
        if (port == 0) begin
            bus.req0_cmd = cmd; bus.req0_op1 = a; bus.req0_op2 = b;
            bus.req0_set_status = set; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_cmd = cmd; bus.req1_op1 = a; bus.req1_op2 = b;
            bus.req1_set_status = set; bus.req1_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: port %0d got no ready within 40 cycles", port);
        end else begin
            @(posedge clk);
        end
        #1;
        if (port == 0) bus.req0_valid = 1'b0;
        else           bus.req1_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.rsp_valid) done = 1'b1;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] p0a[4] = '{32'd16, 32'd32, 32'd48, 32'd64};
    logic [31:0] p0e[4] = '{32'd17, 32'd34, 32'd51, 32'd68};
    logic [31:0] p1a[4] = '{32'd100, 32'd200, 32'd300, 32'd400};
    logic [31:0] p1e[4] = '{32'd99, 32'd198, 32'd297, 32'd396};

    initial begin
        exp_t t;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
        bus.req0_cmd = '0; bus.req1_cmd = '0;
        bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req1_op1 = '0; bus.req1_op2 = '0;
        bus.req0_set_status = 1'b0; bus.req1_set_status = 1'b0;
        bus.rsp_ready = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),   32'd0);
        chk("rst_rsp_id",     32'(bus.rsp_id),      32'd0);
        chk("rst_rsp_data",   bus.rsp_data,         32'd0);
        chk("rst_rsp_status", 32'(bus.rsp_status),  32'd0);
        chk("rst_status_reg", 32'(bus.status_reg),  32'd0);
        chk("rst_alu_in1",    bus.alu_in1,          32'd0);
        chk("rst_alu_in2",    bus.alu_in2,          32'd0);
        chk("rst_alu_cmd",    32'(bus.alu_command), 32'd0);
        chk("rst_alu_cin",    32'(bus.alu_cin),     32'd0);
        chk("rst_ready0",     32'(bus.req0_ready),  32'd0);
        chk("rst_ready1",     32'(bus.req1_ready),  32'd0);
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.rsp_ready = 1'b1;

        // Single ADD with latency probe
        issue(0, C_ADD, 32'd5, 32'd7, 1'b1, 1'b1, 32'd12, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("lat_exec_valid", 32'(bus.rsp_valid),   32'd0);
        chk("exec_alu_in1",   bus.alu_in1,          32'd5);
        chk("exec_alu_cmd",   32'(bus.alu_command), 32'(C_ADD));
        @(negedge clk);
        chk("lat_resp_valid", 32'(bus.rsp_valid),   32'd1);
        @(negedge clk);
        chk("post_rsp_idle",  32'(bus.rsp_valid),   32'd0);
        @(posedge clk); #1;

        // Status handling and carry chain, back-to-back
        issue(1, C_SUB, 32'd3, 32'd3, 1'b1, 1'b1, 32'd0, 4'b1000, 4'b1000);
        issue(1, C_SUB, 32'd3, 32'd3, 1'b0, 1'b1, 32'd0, 4'b1000, 4'b1000);
        issue(1, C_SUB, 32'd2, 32'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0110, 4'b1000);
        issue(0, C_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'd0, 4'b1100, 4'b1100);
        issue(0, C_ADC, 32'd0, 32'd0, 1'b0, 1'b1, 32'd1, 4'b0000, 4'b1100);
        @(negedge clk);
        chk("adc_alu_cin", 32'(bus.alu_cin),     32'd1);
        chk("adc_alu_cmd", 32'(bus.alu_command), 32'(C_ADC));
        drain();

        // Backpressure
        bus.rsp_ready = 1'b0;
        issue(1, C_ADD, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 4'b0000, 4'b1100);
        t.id = 1'b0; t.data = 32'd8; t.flags = 4'b0000; t.sreg = 4'b1100;
        q.push_back(t);
        bus.req0_cmd = C_ADD; bus.req0_op1 = 32'd4; bus.req0_op2 = 32'd4;
        bus.req0_set_status = 1'b0; bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("bp_exec_valid",  32'(bus.rsp_valid),  32'd0);
        chk("bp_exec_ready0", 32'(bus.req0_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid",  32'(bus.rsp_valid),  32'd1);
            chk("bp_data",   bus.rsp_data,        32'd3);
            chk("bp_id",     32'(bus.rsp_id),     32'd1);
            chk("bp_status", 32'(bus.rsp_status), 32'd0);
            chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_grant", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_exec",  32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp_next_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_next_data",  bus.rsp_data,       32'd8);
        drain();

        // Reset during EXEC drops the operation
        issue(0, C_SUB, 32'd1, 32'd2, 1'b1, 1'b0, 32'd0, 4'b0000, 4'b0000);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid",   32'(bus.rsp_valid),  32'd0);
        chk("mid_rst_sreg",    32'(bus.status_reg), 32'd0);
        chk("mid_rst_alu_in1", bus.alu_in1,         32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        issue(1, C_ADD, 32'd5, 32'd7, 1'b1, 1'b1, 32'd12, 4'b0000, 4'b0000);
        drain();

        // Contention with rsp_ready held high
        pop_cyc.delete();
`ifdef ALU_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            t.id = 1'b0; t.data = p0e[k]; t.flags = 4'b0000; t.sreg = 4'b0000; q.push_back(t);
            t.id = 1'b1; t.data = p1e[k]; q.push_back(t);
        end
`else
        for (int k = 0; k < 4; k++) begin
            t.id = 1'b0; t.data = p0e[k]; t.flags = 4'b0000; t.sreg = 4'b0000; q.push_back(t);
        end
        for (int k = 0; k < 4; k++) begin
            t.id = 1'b1; t.data = p1e[k]; t.flags = 4'b0000; t.sreg = 4'b0000; q.push_back(t);
        end
`endif
        fork
            begin
                for (int k = 0; k < 4; k++)
                    issue(0, C_ADD, p0a[k], 32'(k + 1), 1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000);
            end
            begin
                for (int j = 0; j < 4; j++)
                    issue(1, C_SUB, p1a[j], 32'(j + 1), 1'b0, 1'b0, 32'd0, 4'b0000, 4'b0000);
            end
        join
        drain();
        chk("contention_rsp_count", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++)
                chk("throughput_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
